// File: rtl/sdr_pkg.sv
// Shared helpers and constants for the 1-bit SDR receive chain.
package sdr_pkg;

    localparam int unsigned SAT_W = 128;

    // Sigma-delta sample encoding shared with the LVDS input stage.
    localparam logic signed [1:0] PLUS_ONE  = 2'sb01;
    localparam logic signed [1:0] MINUS_ONE = 2'sb11;

    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Arithmetic shift right, then clamp to a signed range of the given width.
    function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] value,
                                                          input int unsigned shift,
                                                          input int unsigned width);
        logic signed [SAT_W-1:0] one_s;
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        one_s   = SAT_W'(1);
        shifted = value >>> shift;
        max_v   = (one_s <<< (width - 1)) - one_s;
        min_v   = ~max_v;
        if (shifted > max_v) return max_v;
        if (shifted < min_v) return min_v;
        return shifted;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One pipelined CIC comb (differential delay 1) advanced by a valid strobe.
module cic_comb_stage #(
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             strobe_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] dly_q, dly_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             vld_q, vld_d;

    always_comb begin
        dly_d  = dly_q;
        diff_d = diff_q;
        vld_d  = strobe_i;
        if (strobe_i) begin
            diff_d = data_i - dly_q;
            dly_d  = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q  <= '0;
            diff_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            dly_q  <= dly_d;
            diff_q <= diff_d;
            vld_q  <= vld_d;
        end
    end

    assign strobe_o = vld_q;
    assign data_o   = diff_q;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator for the +/-1 sigma-delta stream with a saturating,
// single-entry valid/ready output register and a sticky overrun flag.
module cic_decimator
    import sdr_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned STAGES     = 4,
    parameter int unsigned DECIMATION = 64,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned OUT_LSB    = 9
) (
    input  logic                 clock,
    input  logic                 clock_areset_n,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 overrun,
    input  logic                 clear_overrun
);

    localparam int unsigned      CNT_W     = clog2_f(DECIMATION);
    localparam int unsigned      ACC_WIDTH = IN_WIDTH + STAGES * CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DECIMATION - 1);

    logic [ACC_WIDTH-1:0] integ_q [STAGES];
    logic [ACC_WIDTH-1:0] integ_d [STAGES];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] cap_q, cap_d;
    logic                 strobe_q;
    logic                 wrap_c;

    logic [ACC_WIDTH-1:0] comb_data [STAGES+1];
    logic [STAGES:0]      comb_vld;

    logic signed [SAT_W-1:0] comb_ext_c;
    logic [OUT_WIDTH-1:0]    sat_c;
    logic                    transfer_c;
    logic                    valid_q, valid_d;
    logic [OUT_WIDTH-1:0]    data_q, data_d;
    logic                    ovr_q, ovr_d;

    assign wrap_c = in_valid && (cnt_q == CNT_LAST);

    // Integrator chain runs modulo 2^ACC_WIDTH; wrap-around cancels in the combs.
    always_comb begin
        cnt_d = cnt_q;
        cap_d = cap_q;
        for (int unsigned k = 0; k < STAGES; k++) integ_d[k] = integ_q[k];
        if (in_valid) begin
            cnt_d      = wrap_c ? '0 : cnt_q + CNT_W'(1);
            integ_d[0] = integ_q[0] + {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
            for (int unsigned k = 1; k < STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        if (wrap_c) cap_d = integ_q[STAGES-1];
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            for (int unsigned k = 0; k < STAGES; k++) integ_q[k] <= '0;
            cnt_q    <= '0;
            cap_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) integ_q[k] <= integ_d[k];
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            strobe_q <= wrap_c;
        end
    end

    assign comb_vld[0]  = strobe_q;
    assign comb_data[0] = cap_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        cic_comb_stage #(
            .WIDTH (ACC_WIDTH)
        ) u_comb (
            .clk      (clock),
            .rst_n    (clock_areset_n),
            .strobe_i (comb_vld[g]),
            .data_i   (comb_data[g]),
            .strobe_o (comb_vld[g+1]),
            .data_o   (comb_data[g+1])
        );
    end

    assign comb_ext_c = {{(SAT_W-ACC_WIDTH){comb_data[STAGES][ACC_WIDTH-1]}}, comb_data[STAGES]};
    assign sat_c      = OUT_WIDTH'(sat_trunc(comb_ext_c, OUT_LSB, OUT_WIDTH));
    assign transfer_c = valid_q && out_ready;

    // One-entry holding register: a result arriving while full and stalled is dropped.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (transfer_c) valid_d = 1'b0;
        if (clear_overrun) ovr_d = 1'b0;
        if (comb_vld[STAGES]) begin
            if (!valid_q || transfer_c) begin
                valid_d = 1'b1;
                data_d  = sat_c;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: directed +/-1 patterns, handshake/overrun and reset cases.
module tb_cic_decimator;

    localparam int PAT_PLUS  = 0;
    localparam int PAT_MINUS = 1;
    localparam int PAT_ALT   = 2;
    localparam int PAT_31    = 3;
    localparam int R         = 64;

    typedef struct {
        bit          care;
        logic [15:0] val;
        int          k;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic        clock;
    logic        clock_areset_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        overrun;
    logic        clear_overrun;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   lat_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    int          sidx, gidx, outk, care_from;
    bit          push_en, lat_chk;
    logic [15:0] exp_val;

    exp_t e_pop;
    chk_t c_pop;
    int   w_pop, last_rise;
    bit   have_rise, prev_v;

    cic_decimator dut (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .overrun        (overrun),
        .clear_overrun  (clear_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    // Monitor: sole owner of the counters; scores queued checks, transfers and valid timing.
    always @(negedge clock) begin
        while (chk_q.size() > 0) begin
            c_pop = chk_q.pop_front();
            vectors++;
            if (c_pop.act !== c_pop.exp) begin
                miscompares++;
                $display("FAIL %s: got %0h required %0h", c_pop.name, c_pop.act, c_pop.exp);
            end
        end
        if (clock_areset_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected: got transfer %0h required none", out_data);
                end else begin
                    e_pop = exp_q.pop_front();
                    if (e_pop.care) begin
                        vectors++;
                        if (out_data !== e_pop.val) begin
                            miscompares++;
                            $display("FAIL sample_%0d: got %0h required %0h", e_pop.k, out_data, e_pop.val);
                        end
                    end
                end
            end
            if (out_valid && !prev_v && lat_q.size() > 0) begin
                w_pop = lat_q.pop_front();
                vectors++;
                if (cyc - w_pop != 5) begin
                    miscompares++;
                    $display("FAIL valid_latency: got %0d required 5", cyc - w_pop);
                end
                if (have_rise) begin
                    vectors++;
                    if (cyc - last_rise != R) begin
                        miscompares++;
                        $display("FAIL valid_period: got %0d required %0d", cyc - last_rise, R);
                    end
                end
                last_rise = cyc;
                have_rise = 1'b1;
            end
        end else begin
            have_rise = 1'b0;
        end
        prev_v = out_valid;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    function automatic logic [15:0] pat_val(input int pat, input int idx);
        case (pat)
            PAT_PLUS:  return 16'h0001;
            PAT_MINUS: return 16'hFFFF;
            PAT_ALT:   return (idx % 2 == 0) ? 16'h0001 : 16'hFFFF;
            default:   return (idx % 4 == 3) ? 16'hFFFF : 16'h0001;
        endcase
    endfunction

    // One input sample per cycle; the 64th sample of a period queues its expected output.
    task automatic step(input logic [15:0] x);
        exp_t e;
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_data  = x;
        sidx++;
        gidx++;
        if (sidx == R) begin
            sidx = 0;
            outk++;
            if (push_en) begin
                e.care = (outk >= care_from);
                e.val  = exp_val;
                e.k    = outk;
                exp_q.push_back(e);
            end
            if (lat_chk) lat_q.push_back(cyc + 1);
        end
    endtask

    task automatic run(input int pat, input int n);
        for (int i = 0; i < n; i++) step(pat_val(pat, gidx));
    endtask

    task automatic reset_dut();
        clock_areset_n = 1'b0;
        in_valid       = 1'b0;
        in_data        = 16'h0000;
        clear_overrun  = 1'b0;
        exp_q.delete();
        lat_q.delete();
        sidx = 0;
        gidx = 0;
        outk = 0;
        repeat (3) @(posedge clock);
        #1;
        clock_areset_n = 1'b1;
    endtask

    initial begin
        clock_areset_n = 1'b0;
        out_ready      = 1'b1;
        push_en        = 1'b1;
        lat_chk        = 1'b0;
        care_from      = 5;
        exp_val        = 16'h0000;
        reset_dut();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Constant +1: full scale saturates positive
        exp_val = 16'h7FFF;
        run(PAT_PLUS, 8 * R + 8);
        out_ready = 1'b0;
        run(PAT_PLUS, R + 20);
        chk("held_valid", 32'(out_valid), 32'd1);
        chk("held_data", 32'(out_data), 32'h7FFF);
        clock_areset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        chk("async_rst_overrun", 32'(overrun), 32'd0);
        reset_dut();

        // Constant -1 from a fresh reset; first result 64+5 cycles after release
        out_ready = 1'b1;
        exp_val   = 16'h8000;
        run(PAT_MINUS, R + 5);
        chk("release_early", 32'(out_valid), 32'd0);
        run(PAT_MINUS, 1);
        chk("release_first", 32'(out_valid), 32'd1);
        run(PAT_MINUS, 8 * R + 8 - (R + 6));

        // Alternating +1/-1 cancels; also scores out_valid cadence
        reset_dut();
        exp_val = 16'h0000;
        lat_chk = 1'b1;
        run(PAT_ALT, 8 * R + 8);
        lat_chk = 1'b0;

        // Three +1 then one -1: mean 0.5 of full scale
        reset_dut();
        exp_val = 16'h4000;
        run(PAT_31, 8 * R + 8);

        // Handshake: stall holds output 8, drops 9 and 10
        reset_dut();
        exp_val = 16'h8000;
        run(PAT_MINUS, 8 * R);
        out_ready = 1'b0;
        push_en   = 1'b0;
        run(PAT_PLUS, 2 * R + 8);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'h8000);
        chk("stall_overrun", 32'(overrun), 32'd1);
        out_ready     = 1'b1;
        clear_overrun = 1'b1;
        run(PAT_PLUS, 1);
        clear_overrun = 1'b0;
        out_ready     = 1'b0;
        chk("clear_overrun", 32'(overrun), 32'd0);
        chk("clear_valid", 32'(out_valid), 32'd0);
        push_en   = 1'b1;
        care_from = 1000;
        run(PAT_PLUS, R - 9);
        push_en = 1'b0;
        run(PAT_PLUS, R);
        run(PAT_PLUS, 5);
        chk("refill_valid", 32'(out_valid), 32'd1);
        chk("refill_overrun", 32'(overrun), 32'd0);
        clear_overrun = 1'b1;
        run(PAT_PLUS, 1);
        clear_overrun = 1'b0;
        chk("set_wins", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        run(PAT_PLUS, 4);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
